// File: rtl/led_pkg.sv
// Shared definitions for the breathing-LED block: phase encoding and a width helper.
package led_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_RISE    = 3'd1,
    PH_HOLD_HI = 3'd2,
    PH_FALL    = 3'd3,
    PH_HOLD_LO = 3'd4
  } phase_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int safe_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// PWM generator with a period of 2^PWM_BITS-1 cycles; duty is latched only at period start.
module pwm_gen
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_in,
  input  logic                force_off,
  output logic                pwm_out
);

  localparam logic [PWM_BITS-1:0] MAXLVL   = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = MAXLVL - 1'b1;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_eff;

  // The period starting now must already use the newly latched duty.
  assign duty_eff = (pwm_cnt == '0) ? duty_in : duty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
      if (pwm_cnt == '0)
        duty_q <= duty_in;
      pwm_out <= !force_off && (pwm_cnt < duty_eff);
    end
  end

endmodule

// File: rtl/led_breathe.sv
// Breathing LED: PWM duty ramps up, holds, ramps down, holds; doubles as a clock heartbeat.
module led_breathe
  import led_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int STEP_HZ    = 512,
  parameter int PWM_BITS   = 8,
  parameter int HOLD_STEPS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic [2:0]          phase
);

  localparam int DIV     = CLK_HZ / STEP_HZ;
  localparam int PRESC_W = safe_w(DIV);
  localparam int HOLD_W  = safe_w(HOLD_STEPS + 1);

  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
  localparam logic [PWM_BITS-1:0] MAXLVL    = '1;
  localparam logic [PWM_BITS-1:0] LVL_PEN   = MAXLVL - 1'b1;
  localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);

  if (DIV < 2) begin : g_div_chk
    $error("led_breathe: CLK_HZ/STEP_HZ must be at least 2");
  end
  if (HOLD_STEPS < 1) begin : g_hold_chk
    $error("led_breathe: HOLD_STEPS must be at least 1");
  end

  phase_t              ph_q, ph_nx;
  logic [PWM_BITS-1:0] level_q, level_nx;
  logic [PRESC_W-1:0]  presc_q, presc_nx;
  logic [HOLD_W-1:0]   hold_q, hold_nx;
  logic                tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q    <= PH_IDLE;
      level_q <= '0;
      presc_q <= '0;
      hold_q  <= '0;
    end else begin
      ph_q    <= ph_nx;
      level_q <= level_nx;
      presc_q <= presc_nx;
      hold_q  <= hold_nx;
    end
  end

  assign tick = (ph_q != PH_IDLE) && (presc_q == PRESC_MAX);

  always_comb begin
    ph_nx    = ph_q;
    level_nx = level_q;
    hold_nx  = hold_q;
    presc_nx = tick ? '0 : presc_q + 1'b1;
    case (ph_q)
      PH_IDLE: begin
        presc_nx = '0;
        level_nx = '0;
        hold_nx  = '0;
        if (en)
          ph_nx = PH_RISE;
      end
      PH_RISE: begin
        if (tick && level_q != MAXLVL) begin
          level_nx = level_q + 1'b1;
          if (level_q == LVL_PEN) begin
            ph_nx   = PH_HOLD_HI;
            hold_nx = '0;
          end
        end
      end
      PH_HOLD_HI, PH_HOLD_LO: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            ph_nx   = (ph_q == PH_HOLD_HI) ? PH_FALL : PH_RISE;
            hold_nx = '0;
          end else begin
            hold_nx = hold_q + 1'b1;
          end
        end
      end
      PH_FALL: begin
        if (tick && level_q != '0) begin
          level_nx = level_q - 1'b1;
          if (level_q == LVL_ONE) begin
            ph_nx   = PH_HOLD_LO;
            hold_nx = '0;
          end
        end
      end
      default: ph_nx = PH_IDLE;
    endcase
    // Dropping enable abandons the breath from any phase.
    if (!en) begin
      ph_nx    = PH_IDLE;
      level_nx = '0;
      hold_nx  = '0;
      presc_nx = '0;
    end
  end

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk       (clk),
    .rst       (rst),
    .duty_in   (level_q),
    .force_off ((ph_q == PH_IDLE) || !en),
    .pwm_out   (led)
  );

  assign level = level_q;
  assign phase = ph_q;

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe at DIV=8, MAXLVL=7, HOLD_STEPS=2.
module tb_led_breathe;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       led;
  logic [2:0] level;
  logic [2:0] phase;

  int n_assert = 0;
  int n_fail   = 0;
  int ncyc     = 0;

  always #5 clk = ~clk;

  led_breathe #(
    .CLK_HZ     (64),
    .STEP_HZ    (8),
    .PWM_BITS   (3),
    .HOLD_STEPS (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .led   (led),
    .level (level),
    .phase (phase)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, ncyc, obs, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic go_to(input int n);
    while (ncyc < n) tick1();
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_led",   int'(led),   0);
      chk("rst_level", int'(level), 0);
      chk("rst_phase", int'(phase), 0);
    end

    // Cycle numbering starts at the first edge after reset release.
    rst  = 1'b0;
    ncyc = 0;
    tick1();
    chk("rise_entry_phase", int'(phase), 1);
    chk("rise_entry_level", int'(level), 0);
    go_to(8);
    chk("rise_pre_tick_level", int'(level), 0);
    go_to(9);
    chk("rise_first_tick_level", int'(level), 1);

    // Duty 3 period from cycle 29, level changes to 4 mid-period at cycle 33.
    go_to(28);
    for (int n = 29; n <= 42; n++) begin
      tick1();
      chk("pwm_duty3_4_led", int'(led), ((n <= 31) || (n >= 36 && n <= 39)) ? 1 : 0);
      if (n == 32) chk("level_before_change", int'(level), 3);
      if (n == 33) chk("level_after_change", int'(level), 4);
    end

    go_to(56);
    chk("rise_end_level", int'(level), 6);
    chk("rise_end_phase", int'(phase), 1);
    for (int n = 57; n <= 70; n++) begin
      tick1();
      chk("pwm_duty6_7_led", int'(led), (n == 63) ? 0 : 1);
      if (n == 57) begin
        chk("hold_hi_level", int'(level), 7);
        chk("hold_hi_phase", int'(phase), 2);
      end
    end

    go_to(72);
    chk("hold_hi_last_phase", int'(phase), 2);
    go_to(73);
    chk("fall_entry_phase", int'(phase), 3);
    chk("fall_entry_level", int'(level), 7);
    go_to(128);
    chk("fall_end_phase", int'(phase), 3);
    chk("fall_end_level", int'(level), 1);
    go_to(129);
    chk("hold_lo_phase", int'(phase), 4);
    chk("hold_lo_level", int'(level), 0);
    go_to(133);
    for (int n = 134; n <= 140; n++) begin
      tick1();
      chk("pwm_duty0_led", int'(led), 0);
    end
    go_to(144);
    chk("hold_lo_last_phase", int'(phase), 4);
    go_to(145);
    chk("rise2_phase", int'(phase), 1);
    chk("rise2_level", int'(level), 0);

    // Enable drop mid-RISE while the LED is lit.
    go_to(183);
    chk("pre_drop_level", int'(level), 4);
    chk("pre_drop_led",   int'(led),   1);
    en = 1'b0;
    tick1();
    chk("drop_phase", int'(phase), 0);
    chk("drop_level", int'(level), 0);
    chk("drop_led",   int'(led),   0);
    tick1();
    chk("idle_stay_phase", int'(phase), 0);
    en = 1'b1;
    tick1();
    chk("restart_phase", int'(phase), 1);
    chk("restart_level", int'(level), 0);
    go_to(193);
    chk("restart_pre_tick_level", int'(level), 0);
    go_to(194);
    chk("restart_first_tick_level", int'(level), 1);

    // Reset pulse mid-FALL while the LED would be lit.
    go_to(275);
    chk("pre_rst_phase", int'(phase), 3);
    chk("pre_rst_level", int'(level), 5);
    rst = 1'b1;
    tick1();
    chk("midrst_led",   int'(led),   0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_phase", int'(phase), 0);
    rst = 1'b0;
    tick1();
    chk("post_rst_phase", int'(phase), 1);
    chk("post_rst_level", int'(level), 0);
    chk("post_rst_led",   int'(led),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
